// File: rtl/div_exec_unit.sv
// div_exec_unit: iterative restoring DIV/DIVU/REM/REMU unit fed by the DIV reservation station.
// Latency: accept cycle 0, BUSY cycles 1..N (N = 32/BITS_PER_CYCLE), o_req from N+1; specials o_req in cycle 1.
// Backpressure: result held in DONE until i_grant; o_next only in IDLE. Optional DIV_EARLY_OUT_EN: |a|<|b| skips BUSY.

package div_exec_pkg;
  typedef enum logic [2:0] {
    UNKNOWN = 3'd0,
    DIV     = 3'd1,
    DIVU    = 3'd2,
    REM     = 3'd3,
    REMU    = 3'd4
  } instr_name_e;

  typedef struct packed {
    logic clock;
    logic reset;
    logic delete_tag;
  } cs_t;
endpackage

module div_exec_unit
  import div_exec_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  cs_t         cs,
  input  logic [31:0] i_data_1,
  input  logic [31:0] i_data_2,
  input  instr_name_e i_instr_name,
  input  logic        i_tag,
  input  logic [5:0]  i_rrn,
  output logic        o_next,
  output logic        o_req,
  input  logic        i_grant,
  output logic [31:0] o_result,
  output logic [5:0]  o_rrn,
  output logic        o_busy
);

  localparam int N = 32 / BITS_PER_CYCLE;
  localparam logic [5:0] LAST = 6'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state, state_nxt;
  logic        clock, reset, delete_tag;
  logic [31:0] quo, dsr, result;
  logic [32:0] rem;
  logic [5:0]  cnt, rrn;
  logic        is_rem, neg_q, neg_r, tag;

  logic        in_signed, in_rem, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, special_res;
  logic        div_zero, ovf, early, special, accept, flush;
  logic [32:0] r_step;
  logic [31:0] q_step, q_fix, r_fix, final_res;

  assign clock      = cs.clock;
  assign reset      = cs.reset;
  assign delete_tag = cs.delete_tag;

  // Decode the offered record: operand magnitudes and the cases that bypass iteration
  always_comb begin
    in_signed = (i_instr_name == DIV) || (i_instr_name == REM);
    in_rem    = (i_instr_name == REM) || (i_instr_name == REMU);
    a_neg     = in_signed && i_data_1[31];
    b_neg     = in_signed && i_data_2[31];
    a_mag     = a_neg ? -i_data_1 : i_data_1;
    b_mag     = b_neg ? -i_data_2 : i_data_2;
    div_zero  = (i_data_2 == 32'd0);
    ovf       = in_signed && (i_data_1 == 32'h8000_0000) && (i_data_2 == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
    early     = !div_zero && (a_mag < b_mag);
`else
    early     = 1'b0;
`endif
    special   = div_zero || ovf || early;
    if (div_zero)
      special_res = in_rem ? i_data_1 : 32'hFFFF_FFFF;
    else if (ovf)
      special_res = in_rem ? 32'd0 : 32'h8000_0000;
    else
      special_res = in_rem ? i_data_1 : 32'd0;
    accept = (state == IDLE) && (i_instr_name != UNKNOWN) && !(delete_tag && i_tag);
    flush  = delete_tag && tag && (state != IDLE);
  end

  // Resolve BITS_PER_CYCLE quotient bits; the dividend register shifts out as quotient shifts in
  always_comb begin
    r_step = rem;
    q_step = quo;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      r_step = {r_step[31:0], q_step[31]};
      q_step = {q_step[30:0], 1'b0};
      if (r_step >= {1'b0, dsr}) begin
        r_step    = r_step - {1'b0, dsr};
        q_step[0] = 1'b1;
      end
    end
    q_fix     = neg_q ? -q_step : q_step;
    r_fix     = neg_r ? -r_step[31:0] : r_step[31:0];
    final_res = is_rem ? r_fix : q_fix;
  end

  // Next-state logic; a speculative flush beats everything including a grant
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : BUSY;
      BUSY:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (i_grant) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand latches, iteration datapath and registered result
  always_ff @(posedge clock) begin
    if (reset) begin
      quo    <= '0;
      rem    <= '0;
      dsr    <= '0;
      cnt    <= '0;
      rrn    <= '0;
      result <= '0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      tag    <= 1'b0;
    end else if (accept) begin
      quo    <= a_mag;
      rem    <= '0;
      dsr    <= b_mag;
      cnt    <= '0;
      rrn    <= i_rrn;
      is_rem <= in_rem;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      tag    <= i_tag;
      if (special) result <= special_res;
    end else if (state == BUSY) begin
      quo <= q_step;
      rem <= r_step;
      cnt <= cnt + 6'd1;
      if (cnt == LAST) result <= final_res;
    end
  end

  assign o_next   = accept;
  assign o_req    = (state == DONE);
  assign o_busy   = (state != IDLE);
  assign o_result = result;
  assign o_rrn    = rrn;

endmodule

// File: tb/tb_div_exec_unit.sv
// Testbench for div_exec_unit: directed corner cases plus randomized operations.
// Expected results and latencies come from a plain-arithmetic reference model.
// Honours DIV_EARLY_OUT_EN when computing expected latency.

module tb_div_exec_unit;
  import div_exec_pkg::*;

  localparam int BPC = 1;
  localparam int N   = 32 / BPC;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, del;
  cs_t         cs;
  logic [31:0] d1, d2;
  instr_name_e instr;
  logic        itag, grant;
  logic [5:0]  irrn;
  logic        o_next, o_req, o_busy;
  logic [31:0] o_result;
  logic [5:0]  o_rrn;

  int checks = 0;
  int errors = 0;

  assign cs = '{clock: clk, reset: rst, delete_tag: del};

  div_exec_unit #(.BITS_PER_CYCLE(BPC)) dut (
    .cs(cs), .i_data_1(d1), .i_data_2(d2), .i_instr_name(instr), .i_tag(itag),
    .i_rrn(irrn), .o_next(o_next), .o_req(o_req), .i_grant(grant),
    .o_result(o_result), .o_rrn(o_rrn), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mag(input logic [31:0] x, input bit s);
    return (s && x[31]) ? -x : x;
  endfunction

  function automatic logic [31:0] ref_result(input instr_name_e op, input logic [31:0] a, input logic [31:0] b);
    bit s, r;
    int sa, sb;
    s  = (op == DIV) || (op == REM);
    r  = (op == REM) || (op == REMU);
    sa = a;
    sb = b;
    if (b == 0) return r ? a : 32'hFFFF_FFFF;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
    if (s) return r ? 32'(sa % sb) : 32'(sa / sb);
    return r ? a % b : a / b;
  endfunction

  function automatic int ref_lat(input instr_name_e op, input logic [31:0] a, input logic [31:0] b);
    bit s;
    s = (op == DIV) || (op == REM);
    if (b == 0) return 1;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (EO && (mag(a, s) < mag(b, s))) return 1;
    return N + 1;
  endfunction

  // One complete operation; hold==0 keeps grant high from the accept cycle on
  task automatic run_op(input instr_name_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] rrn, input int hold, input string name);
    logic [31:0] exp;
    int lat, cyc;
    exp = ref_result(op, a, b);
    lat = ref_lat(op, a, b);
    @(negedge clk);
    instr = op; d1 = a; d2 = b; itag = 1'b0; irrn = rrn; grant = (hold == 0);
    #1 chk({name, "/next"}, 32'(o_next), 32'd1);
    @(negedge clk);
    instr = UNKNOWN;
    cyc = 1;
    while (o_req !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "/lat"}, cyc, lat);
    chk({name, "/res"}, o_result, exp);
    chk({name, "/rrn"}, 32'(o_rrn), 32'(rrn));
    for (int i = 0; i < hold; i++) begin
      instr = DIVU; d1 = 32'd1; d2 = 32'd1;
      #1 chk({name, "/hold_next"}, 32'(o_next), 32'd0);
      @(negedge clk);
      chk({name, "/hold_res"}, o_result, exp);
      chk({name, "/hold_req"}, 32'(o_req), 32'd1);
    end
    instr = UNKNOWN;
    grant = 1'b1;
    @(negedge clk);
    grant = 1'b0;
    chk({name, "/req_drop"}, 32'(o_req), 32'd0);
    chk({name, "/idle"}, 32'(o_busy), 32'd0);
  endtask

  // DIVU 1000/3 with delete_tag pulsed during cycle 10
  task automatic run_flush(input logic tag, input string name);
    int cyc;
    bit seen;
    @(negedge clk);
    instr = DIVU; d1 = 32'd1000; d2 = 32'd3; itag = tag; irrn = 6'd9; grant = 1'b0;
    #1 chk({name, "/next"}, 32'(o_next), 32'd1);
    @(negedge clk);
    instr = UNKNOWN; itag = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    del = 1'b1;
    @(negedge clk);
    del = 1'b0;
    cyc++;
    if (tag) begin
      chk({name, "/busy"}, 32'(o_busy), 32'd0);
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (o_req === 1'b1) seen = 1'b1;
      end
      chk({name, "/no_req"}, 32'(seen), 32'd0);
    end else begin
      chk({name, "/busy"}, 32'(o_busy), 32'd1);
      while (o_req !== 1'b1 && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      chk({name, "/lat"}, cyc, N + 1);
      chk({name, "/res"}, o_result, 32'd333);
      grant = 1'b1;
      @(negedge clk);
      grant = 1'b0;
      chk({name, "/req_drop"}, 32'(o_req), 32'd0);
    end
  endtask

  initial begin
    instr_name_e op;
    logic [31:0] a, b;
    rst = 1'b1; del = 1'b0; d1 = '0; d2 = '0; instr = UNKNOWN;
    itag = 1'b0; irrn = '0; grant = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst/busy", 32'(o_busy), 32'd0);
    chk("rst/req", 32'(o_req), 32'd0);
    chk("rst/res", o_result, 32'd0);
    chk("rst/rrn", 32'(o_rrn), 32'd0);
    rst = 1'b0;

    run_op(DIVU, 32'd100, 32'd7, 6'd5, 0, "divu_100_7");
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, 6'd1, 1, "div_m7_2");
    run_op(REM, 32'hFFFF_FFF9, 32'd2, 6'd2, 0, "rem_m7_2");
    run_op(DIV, 32'd123, 32'd0, 6'd3, 0, "div_by0");
    run_op(REMU, 32'd9, 32'd0, 6'd4, 0, "remu_by0");
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd6, 0, "div_ovf");
    run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 6'd7, 0, "rem_ovf");
    run_op(DIVU, 32'd3, 32'd9, 6'd8, 0, "early_out");
    run_op(REM, 32'hFFFF_FFFD, 32'd9, 6'd10, 5, "hold5_rem_m3_9");

    run_flush(1'b1, "flush_tag1");
    run_flush(1'b0, "flush_tag0");

    // Reset in the middle of a division loses the result
    @(negedge clk);
    instr = DIV; d1 = 32'd50; d2 = 32'd5; irrn = 6'd33;
    @(negedge clk);
    instr = UNKNOWN;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst/busy", 32'(o_busy), 32'd0);
    chk("midrst/req", 32'(o_req), 32'd0);
    chk("midrst/res", o_result, 32'd0);
    chk("midrst/rrn", 32'(o_rrn), 32'd0);

    for (int i = 0; i < 20; i++) begin
      op = instr_name_e'(3'($urandom_range(1, 4)));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(op, a, b, 6'($urandom_range(0, 63)), $urandom_range(0, 3), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
